// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: command, FIFO read-port and output-stream signals of the burst reader
interface fifo_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_empty;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        input  cmd_valid, cmd_len, fifo_rd_data, fifo_empty, out_ready,
        output cmd_ready, fifo_rd_en, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_rd_data, fifo_empty, out_ready,
        input  cmd_ready, fifo_rd_en, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains cmd_len words from a registered-read FIFO into a valid/ready stream
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16
) (
    input logic                clk,
    input logic                rstn,
    fifo_burst_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [LEN_W-1:0] issue_rem, out_rem;
    logic [WIDTH-1:0] buffer [2];
    logic [1:0]       occ;
    logic             head, inflight, accept, pop;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.cmd_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.out_valid = occ != 2'd0;
    assign bus.out_data  = buffer[head];
    assign bus.out_last  = bus.out_valid && out_rem == LEN_W'(1);
    // Count the word still in the FIFO pipeline so the 2-entry buffer can never overflow
    assign bus.fifo_rd_en = state == RUN && issue_rem != '0 && !bus.fifo_empty &&
                            (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (state == IDLE && accept) state_nxt = bus.cmd_len == '0 ? DONE : RUN;
        if (state == RUN && pop && bus.out_last) state_nxt = DONE;
        if (state == DONE) state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            issue_rem <= '0;
            out_rem   <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            head      <= 1'b0;
            buffer[0] <= '0;
            buffer[1] <= '0;
        end else begin
            inflight <= bus.fifo_rd_en;
            if (accept) begin
                issue_rem <= bus.cmd_len;
                out_rem   <= bus.cmd_len;
            end else begin
                if (bus.fifo_rd_en) issue_rem <= issue_rem - LEN_W'(1);
                if (pop) out_rem <= out_rem - LEN_W'(1);
            end
            // Tail slot is head+occ; when full, a write only lands alongside a pop of head
            if (inflight) buffer[head ^ occ[0]] <= bus.fifo_rd_data;
            if (pop) head <= ~head;
            occ <= occ + 2'(inflight) - 2'(pop);
        end
endmodule
